// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the writeback arbiter and its result FIFO.
package writeback_arbiter_pkg;

    typedef logic [31:0] int_t;
    typedef logic [4:0]  register_id_t;

    // Register 0 is hardwired; writes to it are discarded.
    localparam register_id_t ZERO = 5'd0;

    typedef struct packed {
        register_id_t id;
        int_t         data;
        logic [31:0]  pc;
    } wb_entry_t;

endpackage

// File: rtl/writeback_fifo.sv
// Small in-order FIFO of long-latency writeback entries.
module writeback_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t entry,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= entry;
    end

    // Status and head are read straight from the state.
    always_comb begin
        full  = (count == (AW+1)'(DEPTH));
        empty = (count == '0);
        head  = mem[rd_ptr];
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges pipeline and long-latency writebacks onto the single GPR write port,
// tracks in-flight destinations and flags protocol violations.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         pipeWriteEnabled,
    input  register_id_t pipeWriteId,
    input  int_t         pipeData,
    input  logic [31:0]  pipeProgramCounter,
    input  logic         lateValid,
    output logic         lateReady,
    input  register_id_t lateWriteId,
    input  int_t         lateData,
    input  logic [31:0]  lateProgramCounter,
    input  logic         reserveValid,
    input  register_id_t reserveId,
    output logic [31:0]  pendingMask,
    output logic         stallRequest,
    output logic         hazardError,
    output register_id_t writeId,
    output logic         writeEnabled,
    output int_t         dataWrite,
    output logic [31:0]  programCounterWrite
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic            pipe_active;
    logic            late_live;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic            bypass;
    logic            late_commit;
    wb_entry_t       fifo_head;
    wb_entry_t       late_entry;
    wb_entry_t       commit_entry;
    logic [31:0]     set_vec;
    logic [31:0]     clear_vec;
    logic [31:0]     mask_next;
    logic            hazard_now;
    logic [SW-1:0]   starve_count;
    logic [SW-1:0]   starve_next;

    writeback_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .entry (late_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Port selection, scoreboard next-state, hazard detection and starve count.
    always_comb begin
        pipe_active  = pipeWriteEnabled && (pipeWriteId != ZERO);
        late_live    = lateValid && (lateWriteId != ZERO);
        lateReady    = !fifo_full;
        late_entry   = '{id: lateWriteId, data: lateData, pc: lateProgramCounter};
        pop          = !pipe_active && !fifo_empty;
        // A late result to r0 is accepted but neither bypassed nor buffered.
        bypass       = !pipe_active && fifo_empty && late_live;
        push         = late_live && !fifo_full && !bypass;
        late_commit  = pop || bypass;
        commit_entry = pop ? fifo_head : late_entry;

        set_vec   = '0;
        clear_vec = '0;
        if (reserveValid && (reserveId != ZERO)) set_vec[reserveId] = 1'b1;
        if (late_commit) clear_vec[commit_entry.id] = 1'b1;
        mask_next = (pendingMask & ~clear_vec) | set_vec;

        hazard_now = (|(set_vec & pendingMask & ~clear_vec))
                  || (pipe_active && pendingMask[pipeWriteId])
                  || (late_commit && !pendingMask[commit_entry.id]);

        if (fifo_empty || pop) begin
            starve_next = '0;
        end else if (starve_count != SW'(STARVE_LIMIT)) begin
            starve_next = starve_count + 1'b1;
        end else begin
            starve_next = starve_count;
        end
    end

    // Registered GPR port, scoreboard, sticky error and starvation stall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            writeEnabled        <= 1'b0;
            writeId             <= ZERO;
            dataWrite           <= '0;
            programCounterWrite <= '0;
            pendingMask         <= '0;
            hazardError         <= 1'b0;
            starve_count        <= '0;
            stallRequest        <= 1'b0;
        end else begin
            if (pipe_active) begin
                writeEnabled        <= 1'b1;
                writeId             <= pipeWriteId;
                dataWrite           <= pipeData;
                programCounterWrite <= pipeProgramCounter;
            end else if (late_commit) begin
                writeEnabled        <= 1'b1;
                writeId             <= commit_entry.id;
                dataWrite           <= commit_entry.data;
                programCounterWrite <= commit_entry.pc;
            end else begin
                writeEnabled        <= 1'b0;
            end
            pendingMask  <= mask_next;
            hazardError  <= hazardError | hazard_now;
            starve_count <= starve_next;
            stallRequest <= (starve_next == SW'(STARVE_LIMIT));
        end
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Merges the in-order pipeline writeback stream and the out-of-order long-latency result stream (load miss / mult-div) into the single GPR write port (writeId, writeEnabled, dataWrite, programCounterWrite).
- Buffers long-latency results in a small FIFO.
- Keeps a per-register pending scoreboard so the hazard unit can stall readers and writers of in-flight destinations.
- Sits directly upstream of GeneralPurposeRegisters.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may go undrained before stallRequest asserts.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- pipeWriteEnabled  input  1  pipeline writeback valid this cycle.
- pipeWriteId  input  5 (register_id_t)  pipeline destination.
- pipeData  input  32 (int_t)  pipeline result.
- pipeProgramCounter  input  32  PC of pipeline instruction.
- lateValid  input  1  long-latency result offered.
- lateReady  output  1  FIFO can accept (= !full).
- lateWriteId  input  5  long-latency destination.
- lateData  input  32  long-latency result.
- lateProgramCounter  input  32  PC of long-latency instruction.
- reserveValid  input  1  long-latency op issued this cycle.
- reserveId  input  5  its destination.
- pendingMask  output  32  bit i = register i awaiting long-latency result.
- stallRequest  output  1  request a writeback-free bubble.
- hazardError  output  1  sticky protocol-violation flag.
- writeId  output  5  to GPR.
- writeEnabled  output  1  to GPR.
- dataWrite  output  32  to GPR.
- programCounterWrite  output  32  to GPR.

Behaviour:
- Reset (reset==0, async):
  - FIFO empty; pendingMask=0; starve counter=0.
  - stallRequest=0, hazardError=0, writeEnabled=0, writeId=ZERO, dataWrite=0, programCounterWrite=0.
  - lateReady=1 immediately, combinationally from the empty FIFO.
  - Reset mid-operation discards buffered results and reservations.
- Port ownership: "pipe active" = pipeWriteEnabled && pipeWriteId!=ZERO. Pipe active has absolute priority.
- Output register: GPR-facing outputs are registered, 1-cycle latency from selection. GPR samples on negedge, giving half a cycle of margin.
- Selection each posedge:
  - Pipe active: output the pipe write.
  - Else FIFO non-empty: pop the head and output it.
  - Else lateValid (FIFO empty): output the late entry directly (bypass), without an enqueue.
  - Else writeEnabled=0; other outputs hold their values.
- Enqueue: lateValid && lateReady && !bypass, with lateWriteId!=ZERO. A late result to ZERO is accepted and dropped.
  - lateReady=!full. It does not include same-cycle pop. Push-while-full is never needed.
  - FIFO order is strict; pointers wrap modulo DEPTH. Push and pop in the same cycle leave the count unchanged.
- Scoreboard:
  - Set bit on reserveValid && reserveId!=ZERO.
  - Clear bit when a late entry (pop or bypass) is committed to the output register.
  - Same id set and cleared in the same cycle: set wins.
  - Reserve of an already-set bit (without simultaneous clear): set hazardError.
- Hazards, all setting hazardError; the write itself still proceeds:
  - Pipe active write to a register whose pendingMask bit is 1.
  - Late entry committed for a register whose bit is 0.
- Starvation:
  - Counter increments when the FIFO is non-empty and no pop occurs; resets to 0 on pop or when empty; saturates at STARVE_LIMIT.
  - stallRequest = (counter==STARVE_LIMIT), registered.
  - Upstream must then supply a cycle with pipe inactive. The drain occurs on that cycle and stallRequest falls the next cycle.
  - If the pipe keeps writing, no data is lost; stallRequest stays high.
- hazardError clears only on reset.

Decomposition:
- Shared package: int_t, register_id_t (including ZERO), and a wb_entry_t struct {id, data, pc} used by the FIFO and the output register.
- One sub-module: writeback_fifo (parameterised DEPTH, wb_entry_t payload; push, pop, full, empty, head).
- The arbiter, scoreboard and starve counter stay in writeback_arbiter.

Test Plan:
- Reset low mid-run with 2 entries buffered and pendingMask=0x0000_0030:
  - Expect all outputs 0 and lateReady=1 asynchronously.
  - After release, no stale write appears.
- Pipe-only stream: pipe writes r5=0x1111 @0x400 then r6=0x2222 @0x404 → one cycle later writeId=5, dataWrite=0x1111, programCounterWrite=0x400, then r6; writeEnabled=1 both cycles.
- Bypass and scoreboard:
  - Stimulus: reserve r8; then lateValid r8=0xDEAD with pipe idle.
  - Expect pendingMask=0x100 after the reserve; next cycle writeId=8, dataWrite=0xDEAD; pendingMask returns to 0.
- Buffering and starvation (STARVE_LIMIT=4):
  - Stimulus: reserve r9 and r10; late r9 then r10 while the pipe writes r1..r6 continuously.
  - Expect lateReady=0 when 2 entries are held, and stallRequest=1 after 4 undrained cycles.
  - Then on one idle pipe cycle: r9 is committed and r10 is committed the following idle cycle, in order.
- Hazards:
  - Pipe writes r8 while r8 is pending → hazardError=1, sticky.
  - Separately, reserve r3 twice → hazardError=1.
  - Separately, reserve r3 in the same cycle that the late r3 commits → pendingMask bit 3 stays 1 and no error.
- r0 handling: pipe write to r0 is treated as idle (a FIFO entry drains); late result to r0 is dropped with no GPR write; reserve r0 leaves pendingMask=0.
